// File: rtl/udma_spi_rd_arb_pkg.sv
// Shared types and constants for the SPI uDMA read-port arbiter.
// Channel ids, arbiter states and L2 transfer-size encodings.
package udma_spi_rd_arb_pkg;

    typedef logic ch_id_t;

    localparam ch_id_t CH_CMD = 1'b0;
    localparam ch_id_t CH_TX  = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_state_t;

    localparam logic [1:0] DS_BYTE = 2'd0;
    localparam logic [1:0] DS_HALF = 2'd1;
    localparam logic [1:0] DS_WORD = 2'd2;

endpackage

// File: rtl/udma_spi_rd_arb_id_fifo.sv
// In-order FIFO of channel ids; one entry per granted-but-unanswered L2 read.
// DEPTH must be a power of two so the pointers wrap naturally.
module udma_spi_rd_arb_id_fifo
    import udma_spi_rd_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  ch_id_t din_i,
    output ch_id_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ch_id_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= CH_CMD;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/udma_spi_rd_arbiter.sv
// Shares one L2 read port between the SPI command (ch0) and TX data (ch1) streams.
// Define UDMA_SPI_ARB_CMD_PRIO_EN for strict ch0 priority instead of round-robin.
module udma_spi_rd_arbiter
    import udma_spi_rd_arb_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL  = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           sys_clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     req_i,
    input  logic [1:0][L2_AWIDTH_NOAL-1:0] addr_i,
    input  logic [1:0][1:0]                datasize_i,
    output logic [1:0]                     gnt_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rvalid_o,
    input  logic [1:0]                     rready_i,
    output logic                           l2_req_o,
    output logic [L2_AWIDTH_NOAL-1:0]      l2_addr_o,
    output logic [1:0]                     l2_datasize_o,
    input  logic                           l2_gnt_i,
    input  logic [DATA_WIDTH-1:0]          l2_rdata_i,
    input  logic                           l2_rvalid_i,
    output logic                           l2_rready_o,
    output logic                           busy_o,
    output logic                           err_o
);

    arb_state_t                state_q, state_d;
    ch_id_t                    owner_q, owner_d;
    logic                      l2_req_q, l2_req_d;
    logic [L2_AWIDTH_NOAL-1:0] l2_addr_q, l2_addr_d;
    logic [1:0]                l2_ds_q, l2_ds_d;
    logic                      err_q;
    ch_id_t                    winner;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    ch_id_t                    fifo_head;

`ifdef UDMA_SPI_ARB_CMD_PRIO_EN
    assign winner = req_i[0] ? CH_CMD : CH_TX;
`else
    ch_id_t rr_last_q;

    // On a tie the channel after the last winner goes next.
    assign winner = (req_i == 2'b11) ? ~rr_last_q : (req_i[1] ? CH_TX : CH_CMD);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i)          rr_last_q <= CH_TX;
        else if (fifo_push) rr_last_q <= owner_q;
    end
`endif

    assign fifo_push = (state_q == ARB_REQ) & l2_gnt_i;
    assign fifo_pop  = l2_rvalid_i & l2_rready_o & ~fifo_empty;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        l2_req_d  = l2_req_q;
        l2_addr_d = l2_addr_q;
        l2_ds_d   = l2_ds_q;
        case (state_q)
            ARB_IDLE: begin
                if ((|req_i) && !fifo_full) begin
                    state_d   = ARB_REQ;
                    owner_d   = winner;
                    l2_req_d  = 1'b1;
                    l2_addr_d = addr_i[winner];
                    l2_ds_d   = datasize_i[winner];
                end
            end
            ARB_REQ: begin
                if (l2_gnt_i) begin
                    state_d  = ARB_IDLE;
                    l2_req_d = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            owner_q   <= CH_CMD;
            l2_req_q  <= 1'b0;
            l2_addr_q <= '0;
            l2_ds_q   <= DS_BYTE;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            l2_req_q  <= l2_req_d;
            l2_addr_q <= l2_addr_d;
            l2_ds_q   <= l2_ds_d;
            err_q     <= l2_rvalid_i & fifo_empty;
        end
    end

    udma_spi_rd_arb_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i  (sys_clk_i),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .din_i  (owner_q),
        .dout_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        gnt_o = 2'b00;
        if (fifo_push) gnt_o[owner_q] = 1'b1;
    end

    // With nothing outstanding, responses are drained and flagged as errors.
    always_comb begin
        rvalid_o    = 2'b00;
        l2_rready_o = 1'b1;
        if (!fifo_empty) begin
            rvalid_o[fifo_head] = l2_rvalid_i;
            l2_rready_o         = rready_i[fifo_head];
        end
    end

    assign rdata_o       = l2_rdata_i;
    assign l2_req_o      = l2_req_q;
    assign l2_addr_o     = l2_addr_q;
    assign l2_datasize_o = l2_ds_q;
    assign busy_o        = (state_q == ARB_REQ) | ~fifo_empty;
    assign err_o         = err_q;

endmodule
